exe_stage: RTL and testbench

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/exe_stage_pkg.sv | 32 +++
 rtl/exe_stage_if.sv | 44 ++++
 rtl/exe_stage_val2_gen.sv | 44 ++++
 rtl/exe_stage.sv | 115 +++++++++++
 tb/tb_exe_stage.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Shared processor definitions for the execute stage: ALU opcodes, shift types
// and NZCV bit positions in the status register.
package exe_stage_pkg;

    localparam int WORD_W_DEF = 32;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_MOV = 4'b0001,
        OP_ADD = 4'b0010,
        OP_ADC = 4'b0011,
        OP_SUB = 4'b0100,
        OP_SBC = 4'b0101,
        OP_AND = 4'b0110,
        OP_ORR = 4'b0111,
        OP_EOR = 4'b1000,
        OP_MVN = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX inputs and EXE/MEM outputs of the execute stage, bundled as one bus.
interface exe_stage_if #(
    parameter int WORD_W = 32
);
    logic              freeze;
    logic              flush;
    logic              S_UpdateSig;
    logic              branch;
    logic              memReadEn;
    logic              memWriteEn;
    logic              writeBackEn;
    logic [3:0]        exeCMD;
    logic [WORD_W-1:0] valRn;
    logic [WORD_W-1:0] valRm;
    logic [WORD_W-1:0] PC;
    logic [23:0]       signedImm24;
    logic [3:0]        dest;
    logic              isImmediate;
    logic [11:0]       shiftOperand;

    logic              branchTaken;
    logic [WORD_W-1:0] branchAddr;
    logic [3:0]        status;
    logic [WORD_W-1:0] aluResultOut;
    logic [WORD_W-1:0] valRmOut;
    logic [3:0]        destOut;
    logic              memReadOut;
    logic              memWriteOut;
    logic              writeBackOut;

    modport master (
        output freeze, flush, S_UpdateSig, branch, memReadEn, memWriteEn, writeBackEn,
        output exeCMD, valRn, valRm, PC, signedImm24, dest, isImmediate, shiftOperand,
        input  branchTaken, branchAddr, status, aluResultOut, valRmOut, destOut,
        input  memReadOut, memWriteOut, writeBackOut
    );

    modport slave (
        input  freeze, flush, S_UpdateSig, branch, memReadEn, memWriteEn, writeBackEn,
        input  exeCMD, valRn, valRm, PC, signedImm24, dest, isImmediate, shiftOperand,
        output branchTaken, branchAddr, status, aluResultOut, valRmOut, destOut,
        output memReadOut, memWriteOut, writeBackOut
    );
endinterface

// File: rtl/exe_stage_val2_gen.sv
// Second ALU operand: raw offset for memory ops, rotated immediate, or shifted Rm.
module val2_gen
    import exe_stage_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] i_valRm,
    input  logic [11:0]       i_shiftOperand,
    input  logic              i_isImmediate,
    input  logic              i_memAccess,
    output logic [WORD_W-1:0] o_val2
);

    logic [WORD_W-1:0]   w_imm;
    logic [4:0]          w_rot;
    logic [4:0]          w_amt;
    logic [2*WORD_W-1:0] w_imm_dbl;
    logic [2*WORD_W-1:0] w_rm_dbl;

    assign w_imm     = {{(WORD_W-8){1'b0}}, i_shiftOperand[7:0]};
    assign w_rot     = {i_shiftOperand[11:8], 1'b0};
    assign w_amt     = i_shiftOperand[11:7];
    // Rotation as a shift of the doubled word: the low half is the rotated value.
    assign w_imm_dbl = {w_imm, w_imm} >> w_rot;
    assign w_rm_dbl  = {i_valRm, i_valRm} >> w_amt;

    always_comb begin
        o_val2 = i_valRm;
        if (i_memAccess) begin
            o_val2 = {{(WORD_W-12){1'b0}}, i_shiftOperand};
        end else if (i_isImmediate) begin
            o_val2 = w_imm_dbl[WORD_W-1:0];
        end else begin
            case (shift_e'(i_shiftOperand[6:5]))
                SH_LSL:  o_val2 = i_valRm << w_amt;
                SH_LSR:  o_val2 = i_valRm >> w_amt;
                SH_ASR:  o_val2 = $unsigned($signed(i_valRm) >>> w_amt);
                SH_ROR:  o_val2 = w_rm_dbl[WORD_W-1:0];
                default: o_val2 = i_valRm;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand generation, ALU, NZCV status register, branch target
// and the EXE/MEM pipeline register.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    exe_stage_if.slave  bus
);

    logic [WORD_W-1:0] w_val2;
    logic [WORD_W-1:0] w_opb;
    logic [WORD_W-1:0] w_result;
    logic [WORD_W:0]   w_sum;
    logic              w_cin;
    logic              w_arith;
    logic              w_valid;
    logic [3:0]        w_flags;

    logic [3:0]        r_status;
    logic [WORD_W-1:0] r_alu;
    logic [WORD_W-1:0] r_valRm;
    logic [3:0]        r_dest;
    logic              r_memRead;
    logic              r_memWrite;
    logic              r_writeBack;

    val2_gen #(.WORD_W(WORD_W)) u_val2_gen (
        .i_valRm        (bus.valRm),
        .i_shiftOperand (bus.shiftOperand),
        .i_isImmediate  (bus.isImmediate),
        .i_memAccess    (bus.memReadEn | bus.memWriteEn),
        .o_val2         (w_val2)
    );

    // Subtraction is Rn + ~Val2 + carry-in, so one adder and one overflow rule serve both.
    always_comb begin
        w_opb    = w_val2;
        w_cin    = 1'b0;
        w_arith  = 1'b0;
        w_valid  = 1'b1;
        w_result = '0;
        case (bus.exeCMD)
            OP_ADD: begin w_arith = 1'b1; end
            OP_ADC: begin w_arith = 1'b1; w_cin = r_status[C_IDX]; end
            OP_SUB: begin w_arith = 1'b1; w_opb = ~w_val2; w_cin = 1'b1; end
            OP_SBC: begin w_arith = 1'b1; w_opb = ~w_val2; w_cin = r_status[C_IDX]; end
            default: ;
        endcase
        w_sum = {1'b0, bus.valRn} + {1'b0, w_opb} + {{WORD_W{1'b0}}, w_cin};
        case (bus.exeCMD)
            OP_MOV:  w_result = w_val2;
            OP_MVN:  w_result = ~w_val2;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: w_result = w_sum[WORD_W-1:0];
            OP_AND:  w_result = bus.valRn & w_val2;
            OP_ORR:  w_result = bus.valRn | w_val2;
            OP_EOR:  w_result = bus.valRn ^ w_val2;
            default: w_valid = 1'b0;
        endcase

        w_flags = r_status;
        if (w_valid) begin
            w_flags[N_IDX] = w_result[WORD_W-1];
            w_flags[Z_IDX] = (w_result == '0);
            if (w_arith) begin
                w_flags[C_IDX] = w_sum[WORD_W];
                w_flags[V_IDX] = (bus.valRn[WORD_W-1] == w_opb[WORD_W-1]) &&
                                 (w_result[WORD_W-1] != bus.valRn[WORD_W-1]);
            end
        end
    end

    // EXE/MEM boundary: reset beats flush, flush beats freeze.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_status    <= '0;
            r_alu       <= '0;
            r_valRm     <= '0;
            r_dest      <= '0;
            r_memRead   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_writeBack <= 1'b0;
        end else if (bus.flush) begin
            r_alu       <= '0;
            r_valRm     <= '0;
            r_dest      <= '0;
            r_memRead   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_writeBack <= 1'b0;
        end else if (!bus.freeze) begin
            r_alu       <= w_result;
            r_valRm     <= bus.valRm;
            r_dest      <= bus.dest;
            r_memRead   <= bus.memReadEn;
            r_memWrite  <= bus.memWriteEn;
            r_writeBack <= bus.writeBackEn;
            if (bus.S_UpdateSig && !bus.branch) begin
                r_status <= w_flags;
            end
        end
    end

    assign bus.branchTaken  = bus.branch;
    assign bus.branchAddr   = bus.PC + {{(WORD_W-26){bus.signedImm24[23]}}, bus.signedImm24, 2'b00};
    assign bus.status       = r_status;
    assign bus.aluResultOut = r_alu;
    assign bus.valRmOut     = r_valRm;
    assign bus.destOut      = r_dest;
    assign bus.memReadOut   = r_memRead;
    assign bus.memWriteOut  = r_memWrite;
    assign bus.writeBackOut = r_writeBack;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a behavioural model predicts each edge's outputs,
// a monitor compares them after every rising edge.
module tb_exe_stage;

    typedef struct {
        logic        rst, freeze, flush, S, branch, mr, mw, wb, isImm;
        logic [3:0]  cmd, dest;
        logic [31:0] rn, rm, pc;
        logic [23:0] imm24;
        logic [11:0] shop;
    } stim_t;

    typedef struct {
        logic [31:0] alu, rmout, baddr;
        logic [3:0]  dest, status;
        logic        mr, mw, wb, btaken;
    } exp_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_stage_if #(.WORD_W(32)) bus ();
    exe_stage #(.WORD_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Model state (outputs after the most recent edge).
    logic [3:0]  m_status = 4'b0;
    logic [31:0] m_alu = 0, m_rm = 0;
    logic [3:0]  m_dest = 0;
    logic        m_mr = 0, m_mw = 0, m_wb = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic stim_t base();
        stim_t s;
        s.rst = 1; s.freeze = 0; s.flush = 0; s.S = 0; s.branch = 0;
        s.mr = 0; s.mw = 0; s.wb = 0; s.isImm = 0;
        s.cmd = 0; s.dest = 0; s.rn = 0; s.rm = 0; s.pc = 0; s.imm24 = 0; s.shop = 0;
        return s;
    endfunction

    function automatic logic [31:0] val2_model(stim_t s);
        logic [31:0] x;
        if (s.mr || s.mw) return {20'b0, s.shop};
        if (s.isImm) begin
            x = {24'b0, s.shop[7:0]};
            for (int k = 0; k < 2 * int'(s.shop[11:8]); k++) x = {x[0], x[31:1]};
            return x;
        end
        x = s.rm;
        for (int k = 0; k < int'(s.shop[11:7]); k++) begin
            case (s.shop[6:5])
                2'b00: x = {x[30:0], 1'b0};
                2'b01: x = {1'b0, x[31:1]};
                2'b10: x = {x[31], x[31:1]};
                default: x = {x[0], x[31:1]};
            endcase
        end
        return x;
    endfunction

    task automatic issue(input stim_t s);
        exp_t e;
        logic [31:0] v2, res;
        logic n, z, c, v, defined, arith;
        longint ua, ub, sa, sbv, u, sr, cin;
        @(negedge clk);
        rst = s.rst;
        bus.freeze = s.freeze; bus.flush = s.flush; bus.S_UpdateSig = s.S; bus.branch = s.branch;
        bus.memReadEn = s.mr; bus.memWriteEn = s.mw; bus.writeBackEn = s.wb;
        bus.exeCMD = s.cmd; bus.valRn = s.rn; bus.valRm = s.rm; bus.PC = s.pc;
        bus.signedImm24 = s.imm24; bus.dest = s.dest; bus.isImmediate = s.isImm;
        bus.shiftOperand = s.shop;

        v2 = val2_model(s);
        ua = longint'({32'b0, s.rn}); ub = longint'({32'b0, v2});
        sa = longint'($signed(s.rn)); sbv = longint'($signed(v2));
        {n, z, c, v} = m_status;
        defined = 1; arith = 0; res = 0; u = 0; sr = 0;
        case (s.cmd)
            4'd1: res = v2;
            4'd9: res = ~v2;
            4'd2, 4'd3: begin
                cin = (s.cmd == 4'd3) ? longint'(m_status[1]) : 0;
                u = ua + ub + cin; sr = sa + sbv + cin; arith = 1;
                res = u[31:0]; c = (u >= 64'sd4294967296);
            end
            4'd4, 4'd5: begin
                cin = (s.cmd == 4'd5) ? longint'(!m_status[1]) : 0;
                u = ua - ub - cin; sr = sa - sbv - cin; arith = 1;
                res = u[31:0]; c = (u >= 0);
            end
            4'd6: res = s.rn & v2;
            4'd7: res = s.rn | v2;
            4'd8: res = s.rn ^ v2;
            default: defined = 0;
        endcase
        if (defined) begin
            n = res[31]; z = (res == 0);
            if (arith) v = (sr > SMAX) || (sr < SMIN);
        end

        if (!s.rst) begin
            m_status = 0; m_alu = 0; m_rm = 0; m_dest = 0; m_mr = 0; m_mw = 0; m_wb = 0;
        end else if (s.flush) begin
            m_alu = 0; m_rm = 0; m_dest = 0; m_mr = 0; m_mw = 0; m_wb = 0;
        end else if (!s.freeze) begin
            m_alu = res; m_rm = s.rm; m_dest = s.dest; m_mr = s.mr; m_mw = s.mw; m_wb = s.wb;
            if (s.S && !s.branch) m_status = {n, z, c, v};
        end

        e.alu = m_alu; e.rmout = m_rm; e.dest = m_dest; e.status = m_status;
        e.mr = m_mr; e.mw = m_mw; e.wb = m_wb;
        e.btaken = s.branch;
        e.baddr = s.pc + {{6{s.imm24[23]}}, s.imm24, 2'b00};
        sb.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected entry per edge, compared just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("aluResultOut", bus.aluResultOut, e.alu);
                check("valRmOut", bus.valRmOut, e.rmout);
                check("destOut", {28'b0, bus.destOut}, {28'b0, e.dest});
                check("status", {28'b0, bus.status}, {28'b0, e.status});
                check("ctrl", {29'b0, bus.memReadOut, bus.memWriteOut, bus.writeBackOut},
                      {29'b0, e.mr, e.mw, e.wb});
                check("branchTaken", {31'b0, bus.branchTaken}, {31'b0, e.btaken});
                check("branchAddr", bus.branchAddr, e.baddr);
            end
        end
    end

    initial begin
        stim_t s;
        s = base(); s.rst = 0;
        issue(s); issue(s);
        after_edge();
        check("reset_status", {28'b0, bus.status}, 32'h0);
        check("reset_alu", bus.aluResultOut, 32'h0);

        s = base(); s.cmd = 4'b0010; s.rn = 32'h7FFF_FFFF; s.isImm = 1; s.shop = 12'h001;
        s.S = 1; s.wb = 1; s.dest = 4'd3;
        issue(s); after_edge();
        check("add_ovf_result", bus.aluResultOut, 32'h8000_0000);
        check("add_ovf_status", {28'b0, bus.status}, 32'h9);

        s = base(); s.cmd = 4'b0100; s.rn = 5; s.isImm = 1; s.shop = 12'h005; s.S = 1;
        issue(s); after_edge();
        check("sub_zero_result", bus.aluResultOut, 32'h0);
        check("sub_zero_status", {28'b0, bus.status}, 32'h6);
        s = base(); s.cmd = 4'b0011; s.rn = 1; s.isImm = 1; s.shop = 12'h001;
        issue(s); after_edge();
        check("adc_carry", bus.aluResultOut, 32'h3);

        s = base(); s.cmd = 4'b0001; s.isImm = 1; s.shop = 12'h4FF;
        issue(s); after_edge();
        check("imm_rotate", bus.aluResultOut, 32'hFF00_0000);
        s = base(); s.cmd = 4'b0001; s.rm = 32'h8000_0000; s.shop = 12'h240;
        issue(s); after_edge();
        check("reg_asr", bus.aluResultOut, 32'hF800_0000);

        s = base(); s.branch = 1; s.pc = 32'h100; s.imm24 = 24'hFFFFFE; s.cmd = 4'b0010;
        s.isImm = 1; s.S = 1;
        issue(s); after_edge();
        check("branch_addr", bus.branchAddr, 32'h0000_00F8);
        check("branch_taken", {31'b0, bus.branchTaken}, 32'h1);
        check("branch_status_kept", {28'b0, bus.status}, 32'h6);

        s = base(); s.cmd = 4'b0010; s.rn = 10; s.isImm = 1; s.shop = 12'h002; s.dest = 4'd7;
        issue(s);
        for (int i = 0; i < 3; i++) begin
            s = base(); s.freeze = 1; s.S = 1; s.cmd = 4'b0010; s.rn = $urandom; s.rm = $urandom;
            s.dest = 4'($urandom); s.wb = 1;
            issue(s); after_edge();
            check("freeze_hold_alu", bus.aluResultOut, 32'd12);
            check("freeze_hold_status", {28'b0, bus.status}, 32'h6);
        end
        s = base(); s.flush = 1; s.S = 1; s.cmd = 4'b0100; s.rn = 3; s.isImm = 1; s.shop = 12'h003;
        s.wb = 1; s.dest = 4'd9;
        issue(s); after_edge();
        check("flush_alu", bus.aluResultOut, 32'h0);
        check("flush_dest", {28'b0, bus.destOut}, 32'h0);
        check("flush_status_kept", {28'b0, bus.status}, 32'h6);

        s = base(); s.cmd = 4'b0100; s.rn = 1; s.isImm = 1; s.shop = 12'h002; s.S = 1; s.wb = 1;
        issue(s);
        s = base(); s.rst = 0; s.freeze = 1; s.S = 1; s.cmd = 4'b0010; s.rn = 32'hFFFF_FFFF;
        s.isImm = 1; s.shop = 12'h001; s.wb = 1; s.mr = 1;
        issue(s); after_edge();
        check("rst_freeze_status", {28'b0, bus.status}, 32'h0);
        check("rst_freeze_alu", bus.aluResultOut, 32'h0);
        check("rst_freeze_wb", {31'b0, bus.writeBackOut}, 32'h0);
        s = base(); s.cmd = 4'b0001; s.isImm = 1; s.shop = 12'h007;
        issue(s); after_edge();
        check("first_after_reset", bus.aluResultOut, 32'h7);

        for (int i = 0; i < 600; i++) begin
            s.rst    = ($urandom_range(0, 39) != 0);
            s.freeze = ($urandom_range(0, 5) == 0);
            s.flush  = ($urandom_range(0, 9) == 0);
            s.branch = ($urandom_range(0, 7) == 0);
            s.S      = 1'($urandom);
            s.mr     = ($urandom_range(0, 7) == 0);
            s.mw     = ($urandom_range(0, 7) == 0);
            s.wb     = 1'($urandom);
            s.isImm  = 1'($urandom);
            s.cmd    = 4'($urandom);
            s.dest   = 4'($urandom);
            s.rn     = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
            s.rm     = $urandom;
            s.pc     = $urandom;
            s.imm24  = 24'($urandom);
            s.shop   = 12'($urandom);
            issue(s);
        end

        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
